// File: rtl/construtor_caminho_if.sv
// construtor_caminho_if: path node stream.
// Valid/ready handshake; ultimo marks the fonte beat.
interface construtor_caminho_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ultimo;
  logic                  ready;

  modport master (
    output valid,
    output addr,
    output ultimo,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  ultimo,
    output ready
  );
endinterface

// File: rtl/construtor_caminho.sv
// construtor_caminho: walks the predecessor memory from destino to fonte.
// Streams every path node, destino first, fonte last.
module construtor_caminho #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_PASSOS = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iniciar_in,
  input  logic [ADDR_WIDTH-1:0]   fonte_in,
  input  logic [ADDR_WIDTH-1:0]   destino_in,
  output logic                    anterior_rd_en_out,
  output logic [ADDR_WIDTH-1:0]   anterior_rd_addr_out,
  input  logic [ADDR_WIDTH-1:0]   anterior_rd_data_in,
  construtor_caminho_if.master    caminho,
  output logic                    caminho_pronto_out,
  output logic                    erro_out,
  output logic                    ocupado_out
);

  typedef enum logic [2:0] {
    OCIOSO,
    EMITIR,
    LER,
    AGUARDAR,
    FIM,
    ERRO
  } estado_t;

  localparam logic [ADDR_WIDTH:0] LIMITE =
    (ADDR_WIDTH+1)'(MAX_PASSOS);

  estado_t               estado;
  estado_t               prox;
  logic [ADDR_WIDTH-1:0] atual;
  logic [ADDR_WIDTH-1:0] fonte;
  // One bit wider than an address so MAX_PASSOS itself is reachable.
  logic [ADDR_WIDTH:0]   passos;
  logic [ADDR_WIDTH:0]   passos_inc;
  logic                  eh_fonte;
  logic                  hs;

  assign passos_inc = passos + 1'b1;
  assign eh_fonte   = (atual == fonte);
  assign hs         = (estado == EMITIR) && caminho.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= OCIOSO;
      atual  <= '0;
      fonte  <= '0;
      passos <= '0;
    end else begin
      estado <= prox;
      unique case (1'b1)
        (estado == OCIOSO) && iniciar_in: begin
          fonte  <= fonte_in;
          atual  <= destino_in;
          passos <= '0;
        end
        hs:                   passos <= passos_inc;
        (estado == AGUARDAR): atual  <= anterior_rd_data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    prox                 = estado;
    caminho.valid        = 1'b0;
    caminho.addr         = '0;
    caminho.ultimo       = 1'b0;
    anterior_rd_en_out   = 1'b0;
    anterior_rd_addr_out = '0;
    caminho_pronto_out   = 1'b0;
    erro_out             = 1'b0;
    ocupado_out          = (estado != OCIOSO);
    unique case (estado)
      OCIOSO: begin
        if (iniciar_in) prox = EMITIR;
      end
      EMITIR: begin
        caminho.valid  = 1'b1;
        caminho.addr   = atual;
        caminho.ultimo = eh_fonte;
        if (caminho.ready) begin
          if (eh_fonte)                  prox = FIM;
          else if (passos_inc == LIMITE) prox = ERRO;
          else                           prox = LER;
        end
      end
      LER: begin
        anterior_rd_en_out   = 1'b1;
        anterior_rd_addr_out = atual;
        prox                 = AGUARDAR;
      end
      AGUARDAR: prox = EMITIR;
      FIM: begin
        caminho_pronto_out = 1'b1;
        prox               = OCIOSO;
      end
      ERRO: begin
        erro_out = 1'b1;
        prox     = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_construtor_caminho.sv
// tb_construtor_caminho: random and directed path walks
// checked against a queue-based reference walk.
module tb_construtor_caminho;
  localparam int AW   = 4;
  localparam int MAXP = 5;

  logic          clk;
  logic          rst;
  logic          iniciar;
  logic [AW-1:0] fonte;
  logic [AW-1:0] destino;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_data;
  logic          pronto;
  logic          erro;
  logic          ocupado;
  logic [AW-1:0] mem [16];
  int            total;
  int            bad;
  int            cyc;

  construtor_caminho_if #(.ADDR_WIDTH(AW)) cam ();

  construtor_caminho #(
    .ADDR_WIDTH(AW),
    .MAX_PASSOS(MAXP)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .iniciar_in          (iniciar),
    .fonte_in            (fonte),
    .destino_in          (destino),
    .anterior_rd_en_out  (rd_en),
    .anterior_rd_addr_out(rd_addr),
    .anterior_rd_data_in (rd_data),
    .caminho             (cam.master),
    .caminho_pronto_out  (pronto),
    .erro_out            (erro),
    .ocupado_out         (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Predecessor memory: data one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, cam.valid, 0);
    chk({tag, "_addr"}, {cam.addr, cam.ultimo}, 0);
    chk({tag, "_rd"}, {rd_en, rd_addr}, 0);
    chk({tag, "_flags"}, {pronto, erro, ocupado}, 0);
  endtask

  // rmode: 0 ready=1, 1 random ready, 2 ready=0 on cycles t0+4..t0+7
  task automatic walk(input logic [AW-1:0] f,
                      input logic [AW-1:0] d,
                      input int rmode,
                      input bit intrude);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_q[$];
    logic [AW-1:0] rd_q[$];
    bit            ult_q[$];
    int            hs_c[$];
    int            rd_c[$];
    logic [AW-1:0] n;
    logic [AW-1:0] pa;
    bit            ok, fin, pv, pr, pu;
    int            t0, c, first, np, ne, fin_c, extra;

    n = d;
    ok = 0;
    forever begin
      exp_q.push_back(n);
      if (n == f) begin ok = 1; break; end
      if (exp_q.size() == MAXP) break;
      n = mem[n];
    end

    @(posedge clk); #1;
    iniciar   = 1'b1;
    fonte     = f;
    destino   = d;
    cam.ready = (rmode == 1) ? 1'($urandom) : 1'b1;
    t0 = cyc;
    fin = 0; pv = 0; pr = 0; pu = 0; pa = '0;
    first = -1; np = 0; ne = 0; fin_c = -1;

    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      c = t0 + k;
      if (k == 0) chk("ocioso_t0", ocupado, 0);
      else        chk("ocupado", ocupado, 1);
      if (pv && !pr) begin
        chk("valid_held", cam.valid, 1);
        chk("addr_held", cam.addr, pa);
        chk("ult_held", cam.ultimo, pu);
      end
      if (cam.valid) begin
        if (first < 0) first = c;
        if (cam.ready) begin
          got_q.push_back(cam.addr);
          ult_q.push_back(cam.ultimo);
          hs_c.push_back(c);
        end
      end else begin
        chk("idle_zero", {cam.addr, cam.ultimo}, 0);
      end
      pv = cam.valid; pr = cam.ready;
      pa = cam.addr;  pu = cam.ultimo;
      if (rd_en) begin
        rd_q.push_back(rd_addr);
        rd_c.push_back(c);
      end else begin
        chk("rd_addr_idle", rd_addr, 0);
      end
      if (pronto) np++;
      if (erro)   ne++;
      if (pronto || erro) begin
        fin = 1;
        fin_c = c;
        break;
      end
      @(posedge clk); #1;
      iniciar = 1'b0;
      fonte   = 4'($urandom);
      destino = 4'($urandom);
      if (intrude && k == 1) begin
        iniciar = 1'b1;
        destino = d ^ 4'hf;
      end
      case (rmode)
        0:       cam.ready = 1'b1;
        1:       cam.ready = 1'($urandom);
        default: cam.ready = !((k + 1 >= 4) && (k + 1 <= 7));
      endcase
    end

    chk("terminou", fin, 1);
    chk("n_beats", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("beat", got_q[i], exp_q[i]);
      chk("ultimo", ult_q[i], exp_q[i] == f);
    end
    chk("pronto", np, ok);
    chk("erro", ne, !ok);
    chk("first_lat", first, t0 + 1);
    if (hs_c.size() > 0) chk("fim_lat", fin_c, hs_c[hs_c.size()-1] + 1);
    chk("n_reads", rd_q.size(), exp_q.size() - 1);
    for (int i = 0; i < rd_q.size() && i + 1 < exp_q.size(); i++) begin
      chk("rd_addr", rd_q[i], exp_q[i]);
      if (i < hs_c.size()) chk("rd_timing", rd_c[i], hs_c[i] + 1);
    end
    if (rmode != 1 && hs_c.size() == exp_q.size()) begin
      extra = (rmode == 2 && exp_q.size() >= 2) ? 4 : 0;
      chk("ultimo_hs", hs_c[hs_c.size()-1],
          t0 + 1 + 3 * (exp_q.size() - 1) + extra);
    end

    @(posedge clk); #1;
    iniciar   = 1'b0;
    cam.ready = 1'b1;
    @(negedge clk);
    chk("ocupado_fim", ocupado, 0);
    chk("pulso_unico", {pronto, erro}, 0);
  endtask

  task automatic reset_abort();
    @(posedge clk); #1;
    iniciar = 1'b1; fonte = 4'd0; destino = 4'd5; cam.ready = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ler_rd_en", rd_en, 1);
    chk("ler_rd_addr", rd_addr, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    all_zero("abort");
    @(negedge clk);
    chk("abort_quieto", {pronto, erro, ocupado, cam.valid}, 0);
  endtask

  initial begin
    logic [AW-1:0] f, d;
    rst = 1'b1; iniciar = 1'b0; fonte = '0; destino = '0;
    cam.ready = 1'b0;
    total = 0; bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    all_zero("pos_reset");

    mem[5] = 4'd3; mem[3] = 4'd2; mem[2] = 4'd0;
    walk(4'd0, 4'd5, 0, 0);
    walk(4'd7, 4'd7, 0, 0);
    walk(4'd0, 4'd5, 2, 0);
    mem[4] = 4'd6; mem[6] = 4'd4;
    walk(4'd0, 4'd4, 0, 0);
    walk(4'd0, 4'd5, 0, 1);
    reset_abort();
    walk(4'd0, 4'd3, 1, 0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      d = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        f = d;
        for (int j = 0; j < $urandom_range(0, 6); j++) f = mem[f];
      end else begin
        f = 4'($urandom);
      end
      walk(f, d, $urandom_range(0, 2), (f != d) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/construtor_caminho.md
Name: construtor_caminho

Overview:
- Sits downstream of gerenciador_memoria_anterior and is started by the controller's construir_caminho pulse.
- Walks the predecessor ("anterior") memory backwards from destino to fonte.
- Emits each node address of the path on a valid/ready stream, destino first and fonte last.
- Signals caminho_pronto on a successful walk, or erro when the walk exceeds the step limit (broken or cyclic chain).

Parameters:
- ADDR_WIDTH, 10, width of node address and of the predecessor memory data.
- MAX_PASSOS, 1024, maximum number of nodes emitted before the walk is declared broken (1 ≤ MAX_PASSOS ≤ 2**ADDR_WIDTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- iniciar_in  in  1  one-cycle start pulse (cme_construir_caminho); ignored while ocupado_out=1.
- fonte_in  in  ADDR_WIDTH  source node; sampled on an accepted iniciar_in.
- destino_in  in  ADDR_WIDTH  destination node; sampled on an accepted iniciar_in.
- anterior_rd_en_out  out  1  predecessor memory read enable.
- anterior_rd_addr_out  out  ADDR_WIDTH  predecessor memory read address.
- anterior_rd_data_in  in  ADDR_WIDTH  predecessor of the addressed node; valid exactly 1 cycle after rd_en.
- caminho_valid_out  out  1  path node available.
- caminho_addr_out  out  ADDR_WIDTH  path node address.
- caminho_ultimo_out  out  1  qualifies valid: this node is fonte (last beat).
- caminho_ready_in  in  1  consumer accepts beat (lido).
- caminho_pronto_out  out  1  one-cycle pulse: walk finished successfully.
- erro_out  out  1  one-cycle pulse: step limit exceeded.
- ocupado_out  out  1  walk in progress (state ≠ OCIOSO).

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset: state=OCIOSO, internal atual/fonte/passos=0. All outputs are 0. Reset mid-walk aborts immediately; no pronto or erro pulse is generated.
- States and transitions:
  - OCIOSO: on iniciar_in, latch fonte/destino, atual←destino_in, passos←0, go to EMITIR.
  - EMITIR: valid=1, addr=atual, ultimo=(atual==fonte). Stay until valid&ready (handshake). On handshake passos←passos+1, then:
    - ultimo=1 → FIM.
    - else passos+1 == MAX_PASSOS → ERRO.
    - else → LER.
  - LER: rd_en=1, rd_addr=atual, for exactly 1 cycle → AGUARDAR.
  - AGUARDAR: atual←anterior_rd_data_in → EMITIR.
  - FIM: caminho_pronto_out=1 for 1 cycle → OCIOSO.
  - ERRO: erro_out=1 for 1 cycle → OCIOSO.
- Stream rules:
  - valid, addr and ultimo are stable from assertion until the handshake; valid never drops without a handshake (except on rst).
  - addr and ultimo are 0 when valid=0.
- Throughput: with ready held at 1, beats are accepted every 3 cycles (EMITIR, LER, AGUARDAR).
- Latency: iniciar_in at cycle t → first beat valid at t+1; pronto asserted the cycle after the last handshake.
- fonte==destino: a single beat with ultimo=1, then pronto; no memory read is issued.
- passos is ADDR_WIDTH+1 bits wide and never wraps. The limit check counts the beat just accepted, so at most MAX_PASSOS beats are emitted.
- iniciar_in while ocupado_out=1 is ignored. fonte_in/destino_in changes after the start are ignored.
- rd_en is asserted only in LER; rd_addr is 0 otherwise.

Test Plan:
- Chain 5→3→2→0, fonte=0, destino=5, ready=1 → beats 5,3,2,0 at cycles t+1, t+4, t+7, t+10; ultimo only on 0; pronto at t+11; rd_addr sequence 5,3,2.
- fonte=destino=7 → one beat addr=7 with ultimo=1; pronto the next cycle; rd_en never asserted.
- ready=0 for 4 cycles on the second beat → addr=3 held stable with valid=1 throughout; no read issued until the handshake; remaining sequence unchanged.
- Cyclic memory 4→6→4, fonte=0, MAX_PASSOS=5 → beats 4,6,4,6,4, then erro pulse, no pronto, ocupado returns to 0.
- rst=1 during AGUARDAR → next cycle all outputs 0 and state OCIOSO; a new iniciar then walks correctly from the new destino.
- iniciar pulsed while ocupado_out=1 with a different destino → ignored; the original path completes unchanged.
